lcd_char_ram: RTL

- Parametrised dual-port character buffer for the LCD driver.
- Replaces the fixed 4k x 4 single-port block RAM instance with inferred memory of configurable width and depth, selectable write mode, and a synchronous output set/reset.
- Port A is a random-access host port used by the controller to write and read characters.
- Port S is an autonomous scan engine. It streams a run of consecutive characters to the LCD refresh logic under a valid/ready handshake.

---
 rtl/lcd_ram_pkg.sv | 14 +
 rtl/lcd_ram_scan.sv | 82 ++++++++
 rtl/lcd_char_ram.sv | 93 +++++++++
 3 files changed

// File: rtl/lcd_ram_pkg.sv
// Shared constants for the LCD character buffer: port A write modes and scan FSM encoding.
package lcd_ram_pkg;

    localparam int WM_READ_FIRST  = 0;
    localparam int WM_WRITE_FIRST = 1;
    localparam int WM_NO_CHANGE   = 2;

    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_FETCH = 2'd1,
        SCAN_HOLD  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/lcd_ram_scan.sv
// Autonomous scan engine: walks a run of consecutive addresses and streams each
// character out under a valid/ready handshake, one entry per two cycles at best.
module lcd_ram_scan
    import lcd_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_start,
    input  logic [ADDR_W-1:0] s_base,
    input  logic [ADDR_W:0]   s_len,
    input  logic              s_ready,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              s_valid,
    output logic [DATA_W-1:0] s_data,
    output logic              s_last,
    output logic              s_busy
);

    localparam int CNT_W = ADDR_W + 1;

    scan_state_e       state_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [CNT_W-1:0]  cnt_r;

    assign rd_addr = ptr_r;

    // Scan FSM with pointer, remaining-count and all registered stream outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= SCAN_IDLE;
            ptr_r   <= '0;
            cnt_r   <= '0;
            s_valid <= 1'b0;
            s_last  <= 1'b0;
            s_data  <= '0;
            s_busy  <= 1'b0;
        end else begin
            case (state_r)
                SCAN_IDLE: begin
                    if (s_start && (s_len != CNT_W'(0))) begin
                        ptr_r   <= s_base;
                        cnt_r   <= s_len;
                        s_busy  <= 1'b1;
                        state_r <= SCAN_FETCH;
                    end
                end
                SCAN_FETCH: begin
                    // rd_data is the pre-write contents, so a same-cycle host write loses the race
                    s_data  <= rd_data;
                    s_valid <= 1'b1;
                    s_last  <= (cnt_r == CNT_W'(1));
                    state_r <= SCAN_HOLD;
                end
                SCAN_HOLD: begin
                    if (s_ready) begin
                        s_valid <= 1'b0;
                        s_last  <= 1'b0;
                        ptr_r   <= ptr_r + ADDR_W'(1);
                        cnt_r   <= cnt_r - CNT_W'(1);
                        if (cnt_r == CNT_W'(1)) begin
                            s_busy  <= 1'b0;
                            state_r <= SCAN_IDLE;
                        end else begin
                            state_r <= SCAN_FETCH;
                        end
                    end
                end
                default: begin
                    s_valid <= 1'b0;
                    s_last  <= 1'b0;
                    s_busy  <= 1'b0;
                    state_r <= SCAN_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_char_ram.sv
// Dual-port LCD character buffer: random-access host port A with selectable
// write mode and output set/reset, plus a read-only scan port driven by lcd_ram_scan.
module lcd_char_ram
    import lcd_ram_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 5,
    parameter int                WRITE_MODE = 0,
    parameter logic [DATA_W-1:0] SRVAL      = '0,
    parameter logic [DATA_W-1:0] INIT_OUT   = '0,
    parameter string             INIT_FILE  = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_en,
    input  logic              a_we,
    input  logic              a_ssr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_di,
    output logic [DATA_W-1:0] a_do,
    input  logic              s_start,
    input  logic [ADDR_W-1:0] s_base,
    input  logic [ADDR_W:0]   s_len,
    input  logic              s_ready,
    output logic              s_valid,
    output logic [DATA_W-1:0] s_data,
    output logic              s_last,
    output logic              s_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] scan_addr_s;
    logic [DATA_W-1:0] scan_rd_s;

    // Power-up contents of the array; reset never touches it afterwards
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] = '0;
        end
    end

    // Host write port
    always_ff @(posedge clk) begin
        if (a_en && a_we) begin
            mem_r[a_addr] <= a_di;
        end
    end

    // Host read register; set/reset wins over every write mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_do <= INIT_OUT;
        end else if (a_en) begin
            if (a_ssr) begin
                a_do <= SRVAL;
            end else begin
                case (WRITE_MODE)
                    WM_READ_FIRST:  a_do <= mem_r[a_addr];
                    WM_WRITE_FIRST: a_do <= a_we ? a_di : mem_r[a_addr];
                    WM_NO_CHANGE: begin
                        if (!a_we) begin
                            a_do <= mem_r[a_addr];
                        end
                    end
                    default:        a_do <= mem_r[a_addr];
                endcase
            end
        end
    end

    assign scan_rd_s = mem_r[scan_addr_s];

    lcd_ram_scan #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .s_start (s_start),
        .s_base  (s_base),
        .s_len   (s_len),
        .s_ready (s_ready),
        .rd_data (scan_rd_s),
        .rd_addr (scan_addr_s),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_busy  (s_busy)
    );

endmodule
